guess_input_conditioner: RTL and testbench
==========================================

// Module: guess_input_conditioner
// PURPOSE
//  Front-end stage for memory_game. Synchronizes the raw guess switches and the
//  submit button, debounces the button, and produces one guess event per
//  physical press. Each event carries the switch value sampled at the moment
//  the press is validated. The downstream game logic consumes guesses through
//  a valid/ready handshake.
// PARAMETERS
//  SW_WIDTH     4        width of guess switch bus
//  SYNC_STAGES  2        flops in each input synchronizer (>=2)
//  DB_CYCLES    1250000  stable cycles required to accept a level change (>=2)
// PORTS
//  clk          in   1         system clock, all logic on rising edge
//  rst          in   1         synchronous reset, active-high
//  sw           in   SW_WIDTH  raw asynchronous guess switches
//  btn0         in   1         raw asynchronous submit button, 1 = pressed
//  guess_ready  in   1         downstream can take a guess this cycle
//  guess        out  SW_WIDTH  captured guess; stable while guess_valid=1
//  guess_valid  out  1         guess pending; held until accepted
//  btn_level    out  1         debounced button level
//  press_count  out  8         validated presses, wraps 255->0
//  overrun      out  1         sticky: a press was dropped because a guess was pending
// BEHAVIOUR
//  - Reset (sync, active-high): guess=0, guess_valid=0, btn_level=0,
//    press_count=0, overrun=0, synchronizer flops=0, FSM=IDLE, debounce cnt=0.
//    Reset overrides all other activity, including mid-debounce.
//  - Sync: btn0 and every sw bit pass through SYNC_STAGES flops -> btn_s, sw_s.
//  - Debounce FSM; cnt is cleared on entry to each ARM state and increments each cycle:
//     IDLE        : btn_s=1 -> ARM_PRESS
//     ARM_PRESS   : btn_s=0 -> IDLE; cnt==DB_CYCLES-1 && btn_s=1 -> PRESSED + press event
//     PRESSED     : btn_s=0 -> ARM_RELEASE
//     ARM_RELEASE : btn_s=1 -> PRESSED (no event); cnt==DB_CYCLES-1 && btn_s=0 -> IDLE
//  - btn_level=1 in PRESSED and ARM_RELEASE, otherwise 0 (registered).
//  - Latency: the press event, with guess_valid rising, occurs on the
//    (SYNC_STAGES+DB_CYCLES+1)th rising edge. Count from the first edge that
//    samples btn0=1, provided btn0 stays high. With SYNC_STAGES=2 and
//    DB_CYCLES=4 this is the 7th edge.
//  - On a press event, guess <= sw_s as of that edge, and press_count increments.
//  - Handshake: an acceptance happens at an edge where guess_valid&&guess_ready.
//    guess_valid clears on the acceptance edge unless a press event coincides.
//  - Press event at the same edge as an acceptance: load the new guess;
//    guess_valid stays 1; press_count increments.
//  - Press event while guess_valid=1 and guess_ready=0: the event is dropped.
//    guess is unchanged, press_count is unchanged, and overrun <= 1 (sticky
//    until reset).
//  - guess_ready while guess_valid=0: ignored.
//  - Button held high through reset release is treated as a new press. One
//    event follows after the full latency.
//  - Switch changes while guess_valid=1 never alter guess.
// TESTING  (bench uses SYNC_STAGES=2, DB_CYCLES=4)
//  1. rst 2 cycles; sw=4'b0011; btn0=1 for 12 cycles; guess_ready=0
//     -> guess_valid=1 from 7th edge, guess=4'b0011, press_count=1, btn_level=1.
//  2. btn0=1 for 3 cycles then 0
//     -> guess_valid stays 0, press_count=0, btn_level stays 0.
//  3. Valid press, then on release btn0 bounces 0,1,1,0 (1 cycle each), then stays 0
//     -> exactly one event, press_count=1; btn_level=0 DB_CYCLES cycles after the final fall is synchronized.
//  4. guess 4'b1010 pending; second press with sw=4'b0111 and guess_ready=0
//     -> guess=4'b1010, overrun=1, press_count=1. Then guess_ready=1 for 1 cycle
//     -> guess_valid=0 on the next edge.
//  5. rst asserted on the 5th edge of a press (FSM in ARM_PRESS) and btn0 released
//     -> all outputs 0; no event after reset deasserts.
//  6. 256 valid presses, each accepted with guess_ready=1
//     -> press_count=0, overrun=0, last guess equals last sw value.

Source files
------------

// File: rtl/guess_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : guess_input_conditioner
//  Description : Front end for memory_game. Synchronizes the guess switches
//                and the submit button, debounces the button, and emits one
//                guess per validated press over a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module guess_input_conditioner #(
  parameter int SW_WIDTH    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1250000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW_WIDTH-1:0] sw,
  input  logic                btn0,
  input  logic                guess_ready,
  output logic [SW_WIDTH-1:0] guess,
  output logic                guess_valid,
  output logic                btn_level,
  output logic [7:0]          press_count,
  output logic                overrun
);

  // Debounce counter only needs to reach DB_CYCLES-1.
  localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  // Debounce FSM encoding.
  localparam logic [1:0] S_IDLE        = 2'd0;
  localparam logic [1:0] S_ARM_PRESS   = 2'd1;
  localparam logic [1:0] S_PRESSED     = 2'd2;
  localparam logic [1:0] S_ARM_RELEASE = 2'd3;

  // --------------------------------------------------------------------------
  // Synchronizer chains: index 0 samples the raw pin, the top index is the
  // synchronized value used by the rest of the design.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0]               btn_sync_q, btn_sync_d;
  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_sync_q,  sw_sync_d;
  logic                                 btn_s;
  logic [SW_WIDTH-1:0]                  sw_s;

  // Debounce state.
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_evt;

  // Output-side registers.
  logic [SW_WIDTH-1:0] guess_q, guess_d;
  logic                guess_valid_q, guess_valid_d;
  logic                btn_level_q, btn_level_d;
  logic [7:0]          press_count_q, press_count_d;
  logic                overrun_q, overrun_d;

  // Shift each raw input one stage further down its synchronizer chain.
  always_comb begin
    btn_sync_d = {btn_sync_q[SYNC_STAGES-2:0], btn0};
    sw_sync_d  = {sw_sync_q[SYNC_STAGES-2:0], sw};
  end

  assign btn_s = btn_sync_q[SYNC_STAGES-1];
  assign sw_s  = sw_sync_q[SYNC_STAGES-1];

  // Debounce FSM: a level change is accepted only after DB_CYCLES stable
  // samples; the counter restarts on entry to each arming state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_evt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (btn_s) begin
          state_d = S_ARM_PRESS;
          cnt_d   = '0;
        end
      end
      S_ARM_PRESS: begin
        if (!btn_s) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = S_PRESSED;
          press_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PRESSED: begin
        if (!btn_s) begin
          state_d = S_ARM_RELEASE;
          cnt_d   = '0;
        end
      end
      S_ARM_RELEASE: begin
        // A bounce back high returns to PRESSED without a new event.
        if (btn_s) begin
          state_d = S_PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Debounced level follows the next state so it is a clean registered output.
  always_comb begin
    btn_level_d = (state_d == S_PRESSED) || (state_d == S_ARM_RELEASE);
  end

  // Guess capture and handshake. A press may refill the slot on the same
  // edge it is accepted; a press into an occupied, unaccepted slot is dropped
  // and flagged.
  always_comb begin
    guess_d       = guess_q;
    guess_valid_d = guess_valid_q;
    press_count_d = press_count_q;
    overrun_d     = overrun_q;
    if (press_evt) begin
      if (!guess_valid_q || guess_ready) begin
        guess_d       = sw_s;
        guess_valid_d = 1'b1;
        press_count_d = press_count_q + 8'd1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (guess_valid_q && guess_ready) begin
      guess_valid_d = 1'b0;
    end
  end

  // State registers; reset wins over everything including a debounce in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync_q    <= '0;
      sw_sync_q     <= '0;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      guess_q       <= '0;
      guess_valid_q <= 1'b0;
      btn_level_q   <= 1'b0;
      press_count_q <= 8'd0;
      overrun_q     <= 1'b0;
    end else begin
      btn_sync_q    <= btn_sync_d;
      sw_sync_q     <= sw_sync_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      guess_q       <= guess_d;
      guess_valid_q <= guess_valid_d;
      btn_level_q   <= btn_level_d;
      press_count_q <= press_count_d;
      overrun_q     <= overrun_d;
    end
  end

  assign guess       = guess_q;
  assign guess_valid = guess_valid_q;
  assign btn_level   = btn_level_q;
  assign press_count = press_count_q;
  assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_guess_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_guess_input_conditioner
//  Description : Directed self-checking bench for guess_input_conditioner
//                (SYNC_STAGES=2, DB_CYCLES=4: press event on 7th edge).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_guess_input_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw = 4'd0;
  logic       btn0 = 1'b0;
  logic       guess_ready = 1'b0;
  logic [3:0] guess;
  logic       guess_valid;
  logic       btn_level;
  logic [7:0] press_count;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  guess_input_conditioner #(
    .SW_WIDTH(4), .SYNC_STAGES(2), .DB_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn0(btn0), .guess_ready(guess_ready),
    .guess(guess), .guess_valid(guess_valid), .btn_level(btn_level),
    .press_count(press_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; btn0 = 1'b0; guess_ready = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  // Reset with the button already held: everything must read zero.
  task automatic test_reset();
    rst = 1'b1; sw = 4'b0011; btn0 = 1'b1; guess_ready = 1'b0;
    tick(2);
    total++; if (guess !== 4'd0) begin bad++; $display("FAIL rst_guess got=%h exp=0", guess); end
    total++; if (guess_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", guess_valid); end
    total++; if (btn_level !== 1'b0) begin bad++; $display("FAIL rst_level got=%b exp=0", btn_level); end
    total++; if (press_count !== 8'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", press_count); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
  endtask

  // Button held through reset release counts as a press; event on 7th edge.
  task automatic test_basic_press();
    rst = 1'b0;
    tick(6);
    total++; if (guess_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_e6 got=%b exp=0", guess_valid); end
    tick(1);
    total++; if (guess_valid !== 1'b1) begin bad++; $display("FAIL basic_valid_e7 got=%b exp=1", guess_valid); end
    total++; if (guess !== 4'b0011) begin bad++; $display("FAIL basic_guess got=%b exp=0011", guess); end
    total++; if (press_count !== 8'd1) begin bad++; $display("FAIL basic_count got=%0d exp=1", press_count); end
    total++; if (btn_level !== 1'b1) begin bad++; $display("FAIL basic_level got=%b exp=1", btn_level); end
    tick(5);
    total++; if (guess_valid !== 1'b1) begin bad++; $display("FAIL basic_hold got=%b exp=1", guess_valid); end
    total++; if (press_count !== 8'd1) begin bad++; $display("FAIL basic_count_hold got=%0d exp=1", press_count); end
    btn0 = 1'b0;
  endtask

  // A 3-cycle blip must not get through the debouncer.
  task automatic test_short_glitch();
    do_reset();
    btn0 = 1'b1;
    tick(3);
    btn0 = 1'b0;
    tick(10);
    total++; if (guess_valid !== 1'b0) begin bad++; $display("FAIL glitch_valid got=%b exp=0", guess_valid); end
    total++; if (press_count !== 8'd0) begin bad++; $display("FAIL glitch_count got=%0d exp=0", press_count); end
    total++; if (btn_level !== 1'b0) begin bad++; $display("FAIL glitch_level got=%b exp=0", btn_level); end
  endtask

  // Release bounce 0,1,1,0 yields no extra event; level falls 7 edges after final fall.
  task automatic test_release_bounce();
    do_reset();
    sw = 4'b0001; guess_ready = 1'b1; btn0 = 1'b1;
    tick(10);
    btn0 = 1'b0; tick(1);
    btn0 = 1'b1; tick(1);
    btn0 = 1'b1; tick(1);
    btn0 = 1'b0;
    tick(6);
    total++; if (btn_level !== 1'b1) begin bad++; $display("FAIL bounce_level_e6 got=%b exp=1", btn_level); end
    tick(1);
    total++; if (btn_level !== 1'b0) begin bad++; $display("FAIL bounce_level_e7 got=%b exp=0", btn_level); end
    tick(10);
    total++; if (press_count !== 8'd1) begin bad++; $display("FAIL bounce_count got=%0d exp=1", press_count); end
    total++; if (guess_valid !== 1'b0) begin bad++; $display("FAIL bounce_valid got=%b exp=0", guess_valid); end
    guess_ready = 1'b0;
  endtask

  // Second press while a guess is pending and not ready is dropped.
  task automatic test_overrun();
    do_reset();
    sw = 4'b1010; btn0 = 1'b1;
    tick(7);
    total++; if (guess !== 4'b1010) begin bad++; $display("FAIL ovr_first_guess got=%b exp=1010", guess); end
    btn0 = 1'b0;
    tick(8);
    sw = 4'b0111; btn0 = 1'b1;
    tick(8);
    total++; if (guess !== 4'b1010) begin bad++; $display("FAIL ovr_guess got=%b exp=1010", guess); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    total++; if (press_count !== 8'd1) begin bad++; $display("FAIL ovr_count got=%0d exp=1", press_count); end
    total++; if (guess_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1", guess_valid); end
    btn0 = 1'b0; guess_ready = 1'b1;
    tick(1);
    guess_ready = 1'b0;
    total++; if (guess_valid !== 1'b0) begin bad++; $display("FAIL ovr_accept got=%b exp=0", guess_valid); end
    tick(3);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
  endtask

  // Press event on the same edge as an acceptance reloads the slot.
  task automatic test_back_to_back();
    do_reset();
    sw = 4'b0101; btn0 = 1'b1;
    tick(7);
    btn0 = 1'b0;
    tick(8);
    sw = 4'b1100; btn0 = 1'b1;
    tick(6);
    guess_ready = 1'b1;
    tick(1);
    total++; if (guess_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", guess_valid); end
    total++; if (guess !== 4'b1100) begin bad++; $display("FAIL b2b_guess got=%b exp=1100", guess); end
    total++; if (press_count !== 8'd2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", press_count); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    tick(1);
    total++; if (guess_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", guess_valid); end
    guess_ready = 1'b0; btn0 = 1'b0;
  endtask

  // Reset on the 5th edge of a press aborts the debounce.
  task automatic test_mid_reset();
    do_reset();
    sw = 4'b0110; btn0 = 1'b1;
    tick(4);
    rst = 1'b1; btn0 = 1'b0;
    tick(1);
    total++; if ({guess, guess_valid, btn_level, press_count, overrun} !== 15'd0) begin
      bad++; $display("FAIL midrst_outputs got=%h exp=0", {guess, guess_valid, btn_level, press_count, overrun});
    end
    rst = 1'b0;
    tick(12);
    total++; if (guess_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", guess_valid); end
    total++; if (press_count !== 8'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", press_count); end
  endtask

  // 256 accepted presses wrap the counter back to zero.
  task automatic test_wrap();
    logic [3:0] v;
    logic [3:0] last_v;
    int         accepts;
    accepts = 0;
    last_v  = 4'd0;
    do_reset();
    guess_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      v = 4'(i) ^ 4'h5;
      last_v = v;
      sw = v; btn0 = 1'b1;
      for (int k = 0; k < 8; k++) begin
        tick(1);
        if (guess_valid && guess_ready) accepts++;
      end
      btn0 = 1'b0;
      tick(8);
    end
    total++; if (press_count !== 8'd0) begin bad++; $display("FAIL wrap_count got=%0d exp=0", press_count); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL wrap_overrun got=%b exp=0", overrun); end
    total++; if (guess !== last_v) begin bad++; $display("FAIL wrap_guess got=%h exp=%h", guess, last_v); end
    total++; if (accepts != 256) begin bad++; $display("FAIL wrap_accepts got=%0d exp=256", accepts); end
    guess_ready = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_press();
    test_short_glitch();
    test_release_bounce();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
